// File: rtl/serial_vec_loader_pkg.sv
// serial_vec_loader_pkg: shared constants, state type and slot helper for the serial vector loader
package serial_vec_loader_pkg;
  localparam int N_ELEM = 32;
  localparam int DW = 4;
  localparam int VEC_W = N_ELEM * DW;
  localparam int IDX_W = 5;
  localparam int OFF_W = $clog2(VEC_W);
  localparam int TMR_W = 8;
  localparam int TIMEOUT_DEF = 15;
  typedef enum logic [1:0] {COLLECT, ISSUE, WAIT} state_t;
  function automatic logic [OFF_W-1:0] slot_off(input logic [IDX_W-1:0] idx);
    return OFF_W'((N_ELEM - 1 - int'(idx)) * DW);
  endfunction
endpackage

// File: rtl/serial_vec_loader_nibble_packer.sv
// serial_vec_loader_nibble_packer: writes one nibble per enabled cycle into slot idx of a vector (slot 0 at the MSBs)
module serial_vec_loader_nibble_packer
  import serial_vec_loader_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [DW-1:0]    nib,
  output logic [VEC_W-1:0] vec
);
  always_ff @(posedge clk)
    if (rst) vec <= '0;
    else if (we) vec[slot_off(idx) +: DW] <= nib;
endmodule

// File: rtl/serial_vec_loader.sv
// serial_vec_loader: packs 32 nibble-pair beats into I/W and issues them downstream; WEIGHT_REUSE_EN adds s_wkeep weight reuse
module serial_vec_loader
  import serial_vec_loader_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [DW-1:0]    s_i,
  input  logic [DW-1:0]    s_w,
  input  logic             s_last,
`ifdef WEIGHT_REUSE_EN
  input  logic             s_wkeep,
`endif
  input  logic             down_out_valid,
  output logic             in_valid,
  output logic             weight_valid,
  output logic [VEC_W-1:0] I,
  output logic [VEC_W-1:0] W,
  output logic             frame_err,
  output logic             timeout_err
);
  state_t state, state_nx;
  logic [IDX_W-1:0] idx;
  logic [TMR_W-1:0] timer;
  logic accept, at_end, frame_ok, frame_bad, tmo, keep, keep_now;
  assign accept = s_valid && s_ready;
  assign at_end = idx == IDX_W'(N_ELEM - 1);
  assign frame_ok = accept && at_end && s_last;
  assign frame_bad = accept && (at_end != s_last);
  assign tmo = state == WAIT && !down_out_valid && timer == TMR_W'(TIMEOUT - 1);
`ifdef WEIGHT_REUSE_EN
  logic keep_q;
  always_ff @(posedge clk)
    if (rst) keep_q <= 1'b0;
    else if (accept && idx == '0) keep_q <= s_wkeep;
  assign keep_now = idx == '0 ? s_wkeep : keep_q;
  assign keep = keep_q;
`else
  assign keep_now = 1'b0;
  assign keep = 1'b0;
`endif
  always_ff @(posedge clk)
    state <= rst ? COLLECT : state_nx;
  always_comb
    state_nx = state == COLLECT ? (frame_ok ? ISSUE : COLLECT)
             : state == ISSUE ? WAIT
             : (down_out_valid || tmo) ? COLLECT : WAIT;
  always_comb begin
    s_ready = state == COLLECT;
    in_valid = state == ISSUE;
    weight_valid = state == ISSUE && !keep;
  end
  always_ff @(posedge clk)
    if (rst) begin
      idx <= '0;
      timer <= '0;
      frame_err <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      idx <= (frame_ok || frame_bad) ? '0 : accept ? idx + 1'b1 : idx;
      timer <= (state == WAIT && state_nx == WAIT) ? timer + 1'b1 : '0;
      frame_err <= frame_bad;
      timeout_err <= tmo;
    end
  serial_vec_loader_nibble_packer u_pack_i (
    .clk(clk),
    .rst(rst),
    .we(accept),
    .idx(idx),
    .nib(s_i),
    .vec(I)
  );
  serial_vec_loader_nibble_packer u_pack_w (
    .clk(clk),
    .rst(rst),
    .we(accept && !keep_now),
    .idx(idx),
    .nib(s_w),
    .vec(W)
  );
endmodule

// File: tb/tb_serial_vec_loader.sv
// tb_serial_vec_loader: table-driven frames, reset sequence and randomized traffic checked against a queue-based model
module tb_serial_vec_loader;
  import serial_vec_loader_pkg::*;
  localparam int TMO = 15;
  localparam logic [127:0] SEQ = 128'h0123456789ABCDEF0123456789ABCDEF;
`ifdef WEIGHT_REUSE_EN
  localparam logic KEEP_EN = 1'b1;
`else
  localparam logic KEEP_EN = 1'b0;
`endif
  typedef logic [3:0] nib_t;
  typedef struct {
    int last_at, gap_a, gap_b, dov_at, exp_lat, exp_busy;
    logic [3:0] wv;
    logic keep, exp_ferr, exp_terr;
    logic [127:0] exp_i, exp_w;
  } vec_t;
  logic clk = 0, rst = 1, s_valid = 0, s_last = 0, s_wkeep = 0, down_out_valid = 0;
  logic [3:0] s_i = 0, s_w = 0;
  logic s_ready, in_valid, weight_valid, frame_err, timeout_err;
  logic [127:0] I, W;
  int checks = 0, errors = 0, cyc = 0;
  int phase = 0, waited = 0;
  logic e_ready = 1, e_iv = 0, e_wv = 0, e_ferr = 0, e_terr = 0;
  logic zero = 1, w_known = 1, keep_f = 0, last_acc = 0;
  logic [127:0] e_I = '0, e_W = '0;
  nib_t qi[$], qw[$];
  vec_t tbl[$];
  always #5 clk = ~clk;
  serial_vec_loader #(.TIMEOUT(TMO)) dut (
    .clk(clk),
    .rst(rst),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_i(s_i),
    .s_w(s_w),
    .s_last(s_last),
`ifdef WEIGHT_REUSE_EN
    .s_wkeep(s_wkeep),
`endif
    .down_out_valid(down_out_valid),
    .in_valid(in_valid),
    .weight_valid(weight_valid),
    .I(I),
    .W(W),
    .frame_err(frame_err),
    .timeout_err(timeout_err)
  );
  function automatic logic [127:0] pack(input nib_t q[$]);
    logic [127:0] v = '0;
    foreach (q[k]) v[127 - 4 * k -: 4] = q[k];
    return v;
  endfunction
  function automatic vec_t mk(int last_at, int gap_a, int gap_b, int dov_at, int lat, int busy,
                              logic [3:0] wv, logic keep, logic ferr, logic terr,
                              logic [127:0] ei, logic [127:0] ew);
    vec_t v;
    v.last_at = last_at; v.gap_a = gap_a; v.gap_b = gap_b; v.dov_at = dov_at;
    v.exp_lat = lat; v.exp_busy = busy; v.wv = wv; v.keep = keep;
    v.exp_ferr = ferr; v.exp_terr = terr; v.exp_i = ei; v.exp_w = ew;
    return v;
  endfunction
  function automatic void model();
    e_iv = 0; e_wv = 0; e_ferr = 0; e_terr = 0;
    last_acc = !rst && phase == 0 && s_valid;
    if (rst) begin
      phase = 0; qi.delete(); qw.delete();
      e_I = '0; e_W = '0; zero = 1; w_known = 1;
    end else if (phase == 0) begin
      if (s_valid) begin
        if (qi.size() == 0) keep_f = KEEP_EN && s_wkeep;
        qi.push_back(s_i); qw.push_back(s_w); zero = 0;
        if (s_last != (qi.size() == N_ELEM)) begin
          e_ferr = 1; w_known = w_known && keep_f; qi.delete(); qw.delete();
        end else if (s_last) begin
          phase = 1; e_iv = 1; e_I = pack(qi);
          if (!keep_f) begin e_wv = 1; e_W = pack(qw); w_known = 1; end
          qi.delete(); qw.delete();
        end
      end
    end else if (phase == 1) begin
      phase = 2; waited = 0;
    end else begin
      waited++;
      if (down_out_valid) phase = 0;
      else if (waited == TMO) begin phase = 0; e_terr = 1; end
    end
    e_ready = phase == 0;
  endfunction
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask
  task automatic cycle();
    @(posedge clk);
    model();
    #1;
    cyc++;
    chk("s_ready", s_ready, e_ready);
    chk("in_valid", in_valid, e_iv);
    chk("weight_valid", weight_valid, e_wv);
    chk("frame_err", frame_err, e_ferr);
    chk("timeout_err", timeout_err, e_terr);
    if (e_iv || zero) chk("I", I, e_I);
    if ((e_iv && w_known) || zero) chk("W", W, e_W);
  endtask
  task automatic run_frame(input vec_t v);
    int c0 = 0, busy = 1;
    logic terr = 0;
    for (int k = 0; k <= v.last_at; k++) begin
      s_valid = 1; s_i = 4'(k); s_w = v.wv; s_last = k == v.last_at; s_wkeep = v.keep && k == 0;
      cycle();
      if (k == 0) c0 = cyc;
      if (k == v.gap_a || k == v.gap_b) begin
        s_valid = 0; s_last = 0;
        repeat (3) cycle();
      end
    end
    s_valid = 0; s_last = 0; s_wkeep = 0;
    chk("tbl frame_err", frame_err, v.exp_ferr);
    chk("tbl in_valid", in_valid, !v.exp_ferr);
    chk("tbl weight_valid", weight_valid, !v.exp_ferr && !v.keep);
    chk("tbl s_ready", s_ready, v.exp_ferr);
    if (!v.exp_ferr) begin
      chk("tbl latency", cyc - c0, v.exp_lat);
      chk("tbl I", I, v.exp_i);
      chk("tbl W", W, v.exp_w);
      for (int t = 0; t < 20 && !s_ready; t++) begin
        down_out_valid = t == v.dov_at;
        cycle();
        down_out_valid = 0;
        terr = terr | timeout_err;
        if (!s_ready) busy++;
      end
      chk("tbl timeout seen", terr, v.exp_terr);
      chk("tbl busy cycles", busy, v.exp_busy);
      chk("tbl ready after", s_ready, 1);
    end
  endtask
  initial begin
    int src_k = 0, len = 32;
    tbl.push_back(mk(31, -1, -1, 7, 31, 8, 4'h1, 0, 0, 0, SEQ, {32{4'h1}}));
    tbl.push_back(mk(31, 5, 20, 7, 37, 8, 4'h1, 0, 0, 0, SEQ, {32{4'h1}}));
    tbl.push_back(mk(10, -1, -1, 0, 0, 0, 4'h1, 0, 1, 0, SEQ, {32{4'h1}}));
    tbl.push_back(mk(31, -1, -1, 3, 31, 4, 4'hA, 0, 0, 0, SEQ, {32{4'hA}}));
    tbl.push_back(mk(31, -1, -1, 99, 31, 16, 4'h1, 0, 0, 1, SEQ, {32{4'h1}}));
    tbl.push_back(mk(31, -1, -1, 15, 31, 16, 4'h5, 0, 0, 0, SEQ, {32{4'h5}}));
`ifdef WEIGHT_REUSE_EN
    tbl.push_back(mk(31, -1, -1, 3, 31, 4, 4'h2, 0, 0, 0, SEQ, {32{4'h2}}));
    tbl.push_back(mk(31, -1, -1, 3, 31, 4, 4'h7, 1, 0, 0, SEQ, {32{4'h2}}));
`endif
    repeat (2) cycle();
    rst = 0;
    cycle();
    chk("reset s_ready", s_ready, 1);
    chk("reset in_valid", in_valid, 0);
    chk("reset I", I, 0);
    chk("reset W", W, 0);
    foreach (tbl[n]) run_frame(tbl[n]);
    for (int k = 0; k <= 20; k++) begin
      s_valid = 1; s_i = 4'(k); s_w = 4'h3; s_last = 0;
      cycle();
    end
    s_valid = 0; rst = 1;
    cycle();
    rst = 0;
    chk("mid reset s_ready", s_ready, 1);
    chk("mid reset outs", {in_valid, weight_valid, frame_err, timeout_err}, 0);
    chk("mid reset I", I, 0);
    chk("mid reset W", W, 0);
    run_frame(tbl[2]);
    run_frame(tbl[0]);
    for (int c = 0; c < 4000; c++) begin
      if (!s_valid || last_acc || rst) begin
        s_valid = $urandom_range(0, 3) != 0;
        s_i = 4'($urandom); s_w = 4'($urandom);
        s_last = src_k == len - 1;
        s_wkeep = src_k == 0 && $urandom_range(0, 1) == 1;
      end
      rst = $urandom_range(0, 599) == 0;
      down_out_valid = $urandom_range(0, 11) == 0;
      cycle();
      if (rst) src_k = 0;
      else if (last_acc) begin
        src_k = s_last ? 0 : src_k + 1;
        if (s_last) len = $urandom_range(0, 7) == 0 ? int'($urandom_range(1, 33)) : 32;
      end
    end
    rst = 0; s_valid = 0; down_out_valid = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
